// File: rtl/disc_pkg.sv
// Shared state encoding for the multi-channel window discriminator.
package disc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRACK   = 2'd1,
    ST_STIM    = 2'd2,
    ST_REFRACT = 2'd3
  } state_t;

endpackage

// File: rtl/disc_channel_qual.sv
// Per-channel window compare plus pass/qualify flags (purely combinational).
module disc_channel_qual
  import disc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic [CNT_W-1:0] track_count_i,
  input  logic [CNT_W-1:0] start_win_i,
  input  logic [CNT_W-1:0] stop_win_i,
  input  logic             ch_en_i,
  input  logic             thresh_i,
  input  logic             edge_type_i,
  output logic             in_window_o,
  output logic             qual_o,
  output logic             pass_o
);

  // An inverted window (start > stop) can never satisfy both bounds.
  assign in_window_o = (start_win_i <= track_count_i) && (track_count_i <= stop_win_i);
  assign qual_o      = ch_en_i & in_window_o;
  assign pass_o      = thresh_i ^ edge_type_i;

endmodule

// File: rtl/window_discriminator_multi.sv
// Multi-channel window discriminator FSM driving the stimulation trigger.
// Optional refractory state enabled by defining WINDOW_DISC_REFRACTORY_EN.
module window_discriminator_multi
  import disc_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int CNT_W = 16,
  parameter int EVT_W = 16
) (
  input  logic                  dataclk,
  input  logic                  reset_n,
  input  logic                  sample_tick,
  input  logic                  fsm_en,
  input  logic                  combine_or,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       thresh_in,
  input  logic [N_CH-1:0]       edge_type,
  input  logic [N_CH*CNT_W-1:0] start_win,
  input  logic [N_CH*CNT_W-1:0] stop_win,
  input  logic [CNT_W-1:0]      stop_max,
  input  logic [CNT_W-1:0]      refract_len,
  input  logic                  clear_evt,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      track_count,
  output logic [N_CH-1:0]       in_window,
  output logic                  stim_pulse,
  output logic                  stim_active,
  output logic [EVT_W-1:0]      evt_count
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   track_q, track_d;
  logic [EVT_W-1:0]   evt_q, evt_d;
  logic               pulse_q, pulse_d;
  logic               evt_inc;
  logic [N_CH-1:0]    qual, pass;
  logic               advance;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    disc_channel_qual #(.CNT_W(CNT_W)) u_qual (
      .track_count_i (track_q),
      .start_win_i   (start_win[i*CNT_W +: CNT_W]),
      .stop_win_i    (stop_win[i*CNT_W +: CNT_W]),
      .ch_en_i       (ch_en[i]),
      .thresh_i      (thresh_in[i]),
      .edge_type_i   (edge_type[i]),
      .in_window_o   (in_window[i]),
      .qual_o        (qual[i]),
      .pass_o        (pass[i])
    );
  end

  // Channels outside their window are "don't care" in AND mode.
  assign advance = combine_or ? |(qual & pass)
                              : (|ch_en) & (&(pass | ~qual));

`ifdef WINDOW_DISC_REFRACTORY_EN
  logic [CNT_W-1:0] refr_q, refr_d;
`else
  logic unused_refract;
  assign unused_refract = ^refract_len;
`endif

  always_comb begin
    state_d = state_q;
    track_d = track_q;
    pulse_d = 1'b0;
    evt_inc = 1'b0;
`ifdef WINDOW_DISC_REFRACTORY_EN
    refr_d  = refr_q;
`endif
    if (!fsm_en) begin
      state_d = ST_IDLE;
      track_d = '0;
`ifdef WINDOW_DISC_REFRACTORY_EN
      refr_d  = '0;
`endif
    end else if (sample_tick) begin
      case (state_q)
        ST_IDLE: begin
          if (advance) begin
            state_d = ST_TRACK;
            track_d = CNT_W'(1);
          end else begin
            track_d = '0;
          end
        end
        ST_TRACK: begin
          if (advance && (track_q >= stop_max)) begin
            state_d = ST_STIM;
            track_d = '0;
            pulse_d = 1'b1;
            evt_inc = 1'b1;
          end else if (advance) begin
            track_d = sat_inc(track_q);
          end else begin
            state_d = ST_IDLE;
            track_d = '0;
          end
        end
        ST_STIM: begin
`ifdef WINDOW_DISC_REFRACTORY_EN
          state_d = ST_REFRACT;
          refr_d  = refract_len;
`else
          state_d = ST_IDLE;
`endif
        end
        default: begin
`ifdef WINDOW_DISC_REFRACTORY_EN
          // A load of 0 exits on the first tick, same as a load of 1.
          if (refr_q <= CNT_W'(1)) begin
            state_d = ST_IDLE;
            refr_d  = '0;
          end else begin
            refr_d  = refr_q - CNT_W'(1);
          end
`else
          state_d = ST_IDLE;
          track_d = '0;
`endif
        end
      endcase
    end

    if (clear_evt) evt_d = evt_inc ? EVT_W'(1) : '0;
    else           evt_d = evt_q + EVT_W'(evt_inc);
  end

  always_ff @(posedge dataclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      track_q <= '0;
      evt_q   <= '0;
      pulse_q <= 1'b0;
`ifdef WINDOW_DISC_REFRACTORY_EN
      refr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      track_q <= track_d;
      evt_q   <= evt_d;
      pulse_q <= pulse_d;
`ifdef WINDOW_DISC_REFRACTORY_EN
      refr_q  <= refr_d;
`endif
    end
  end

  assign state       = state_q;
  assign track_count = track_q;
  assign stim_pulse  = pulse_q;
  assign stim_active = (state_q == ST_STIM);
  assign evt_count   = evt_q;

endmodule

// File: tb/tb_window_discriminator_multi.sv
// Directed bench for window_discriminator_multi with hand-computed expectations.
module tb_window_discriminator_multi;

  localparam int N_CH  = 8;
  localparam int CNT_W = 16;
  localparam int EVT_W = 16;

  logic                  dataclk;
  logic                  reset_n;
  logic                  sample_tick;
  logic                  fsm_en;
  logic                  combine_or;
  logic [N_CH-1:0]       ch_en;
  logic [N_CH-1:0]       thresh_in;
  logic [N_CH-1:0]       edge_type;
  logic [N_CH*CNT_W-1:0] start_win;
  logic [N_CH*CNT_W-1:0] stop_win;
  logic [CNT_W-1:0]      stop_max;
  logic [CNT_W-1:0]      refract_len;
  logic                  clear_evt;
  logic [1:0]            state;
  logic [CNT_W-1:0]      track_count;
  logic [N_CH-1:0]       in_window;
  logic                  stim_pulse;
  logic                  stim_active;
  logic [EVT_W-1:0]      evt_count;

  int checks;
  int failures;

  window_discriminator_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .EVT_W(EVT_W)) dut (
    .dataclk     (dataclk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .fsm_en      (fsm_en),
    .combine_or  (combine_or),
    .ch_en       (ch_en),
    .thresh_in   (thresh_in),
    .edge_type   (edge_type),
    .start_win   (start_win),
    .stop_win    (stop_win),
    .stop_max    (stop_max),
    .refract_len (refract_len),
    .clear_evt   (clear_evt),
    .state       (state),
    .track_count (track_count),
    .in_window   (in_window),
    .stim_pulse  (stim_pulse),
    .stim_active (stim_active),
    .evt_count   (evt_count)
  );

  initial dataclk = 1'b0;
  always #5 dataclk = ~dataclk;

  task automatic set_win(input int ch, input int s, input int e);
    start_win[ch*CNT_W +: CNT_W] = CNT_W'(s);
    stop_win[ch*CNT_W +: CNT_W]  = CNT_W'(e);
  endtask

  task automatic do_tick();
    sample_tick = 1'b1;
    @(posedge dataclk);
    #1;
    sample_tick = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge dataclk);
    #1;
  endtask

  task automatic test_reset();
    fsm_en = 1'b1; combine_or = 1'b0; ch_en = 8'h03; thresh_in = 8'h03;
    stop_max = 16'd100;
    for (int i = 0; i < 5; i++) do_tick();
    checks++;
    if (track_count !== 16'd5) begin
      failures++; $display("FAIL pre_reset_track got=%0d exp=5", track_count);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || track_count !== 16'd0 || evt_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_async got state=%0d track=%0d evt=%0d exp 0/0/0", state, track_count, evt_count);
    end
    checks++;
    if (in_window !== 8'hFF || stim_pulse !== 1'b0) begin
      failures++; $display("FAIL reset_outputs got inwin=%h pulse=%b exp ff/0", in_window, stim_pulse);
    end
    thresh_in = 8'h00;
    idle_cycle();
    reset_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_and_stim();
    logic [1:0] exp_st [4] = '{2'd1, 2'd1, 2'd1, 2'd2};
    stop_max = 16'd3; ch_en = 8'h03; thresh_in = 8'h03; combine_or = 1'b0;
    for (int t = 0; t < 4; t++) begin
      do_tick();
      checks++;
      if (state !== exp_st[t]) begin
        failures++; $display("FAIL and_state tick%0d got=%0d exp=%0d", t, state, exp_st[t]);
      end
      if (t == 0) begin
        idle_cycle();
        checks++;
        if (state !== 2'd1 || track_count !== 16'd1) begin
          failures++; $display("FAIL hold_no_tick got state=%0d track=%0d exp 1/1", state, track_count);
        end
      end
    end
    checks++;
    if (stim_pulse !== 1'b1 || stim_active !== 1'b1 || evt_count !== 16'd1) begin
      failures++;
      $display("FAIL and_stim got pulse=%b active=%b evt=%0d exp 1/1/1", stim_pulse, stim_active, evt_count);
    end
    idle_cycle();
    checks++;
    if (stim_pulse !== 1'b0 || state !== 2'd2) begin
      failures++; $display("FAIL pulse_width got pulse=%b state=%0d exp 0/2", stim_pulse, state);
    end
    thresh_in = 8'h00;
    do_tick();
    checks++;
    if (state !== 2'd0) begin
      failures++; $display("FAIL stim_exit got=%0d exp=0", state);
    end
  endtask

  task automatic test_and_fail();
    thresh_in = 8'h03;
    do_tick(); do_tick();
    thresh_in = 8'h01;
    do_tick();
    checks++;
    if (state !== 2'd0 || track_count !== 16'd0 || stim_pulse !== 1'b0 || evt_count !== 16'd1) begin
      failures++;
      $display("FAIL and_fail got state=%0d track=%0d pulse=%b evt=%0d exp 0/0/0/1", state, track_count, stim_pulse, evt_count);
    end
    set_win(1, 5, 10);
    thresh_in = 8'h03;
    do_tick(); do_tick();
    thresh_in = 8'h01;
    do_tick();
    checks++;
    if (state !== 2'd1 || track_count !== 16'd3) begin
      failures++; $display("FAIL out_of_win_ignored got state=%0d track=%0d exp 1/3", state, track_count);
    end
    do_tick();
    checks++;
    if (state !== 2'd2 || evt_count !== 16'd2) begin
      failures++; $display("FAIL out_of_win_stim got state=%0d evt=%0d exp 2/2", state, evt_count);
    end
    thresh_in = 8'h00;
    do_tick();
    set_win(1, 0, 100);
  endtask

  task automatic test_or_mode();
    combine_or = 1'b1; ch_en = 8'hFF; thresh_in = 8'h80;
    for (int t = 0; t < 4; t++) do_tick();
    checks++;
    if (state !== 2'd2 || evt_count !== 16'd3) begin
      failures++; $display("FAIL or_stim got state=%0d evt=%0d exp 2/3", state, evt_count);
    end
    ch_en = 8'h00; thresh_in = 8'hFF;
    do_tick(); do_tick(); do_tick();
    checks++;
    if (state !== 2'd0) begin
      failures++; $display("FAIL or_no_chan got=%0d exp=0", state);
    end
    combine_or = 1'b0;
    do_tick();
    checks++;
    if (state !== 2'd0) begin
      failures++; $display("FAIL and_no_chan got=%0d exp=0", state);
    end
  endtask

  task automatic test_fsm_en_clear();
    ch_en = 8'h03; thresh_in = 8'h03;
    do_tick(); do_tick(); do_tick();
    fsm_en = 1'b0;
    do_tick();
    checks++;
    if (state !== 2'd0 || track_count !== 16'd0 || stim_pulse !== 1'b0 || evt_count !== 16'd3) begin
      failures++;
      $display("FAIL fsm_en_override got state=%0d track=%0d pulse=%b evt=%0d exp 0/0/0/3", state, track_count, stim_pulse, evt_count);
    end
    fsm_en = 1'b1;
    do_tick(); do_tick(); do_tick();
    clear_evt = 1'b1;
    do_tick();
    clear_evt = 1'b0;
    checks++;
    if (state !== 2'd2 || evt_count !== 16'd1) begin
      failures++; $display("FAIL clear_with_stim got state=%0d evt=%0d exp 2/1", state, evt_count);
    end
    thresh_in = 8'h00;
    do_tick();
    clear_evt = 1'b1;
    idle_cycle();
    clear_evt = 1'b0;
    checks++;
    if (evt_count !== 16'd0) begin
      failures++; $display("FAIL clear_plain got=%0d exp=0", evt_count);
    end
  endtask

  task automatic test_boundaries();
    stop_max = 16'd0; thresh_in = 8'h03;
    do_tick(); do_tick();
    checks++;
    if (state !== 2'd2 || evt_count !== 16'd1) begin
      failures++; $display("FAIL stop_max0 got state=%0d evt=%0d exp 2/1", state, evt_count);
    end
    thresh_in = 8'h00;
    do_tick();
    set_win(0, 10, 5);
    set_win(2, 0, 0);
    #1;
    checks++;
    if (in_window !== 8'hFE) begin
      failures++; $display("FAIL inverted_win got=%h exp=fe", in_window);
    end
    thresh_in = 8'h03; edge_type = 8'h02; stop_max = 16'd3;
    do_tick();
    checks++;
    if (state !== 2'd0) begin
      failures++; $display("FAIL edge_type_fail got=%0d exp=0", state);
    end
    thresh_in = 8'h01;
    do_tick();
    checks++;
    if (state !== 2'd1 || in_window !== 8'hFA) begin
      failures++; $display("FAIL edge_type_pass got state=%0d inwin=%h exp 1/fa", state, in_window);
    end
    thresh_in = 8'h00; edge_type = 8'h00;
    do_tick();
    set_win(0, 0, 100); set_win(2, 0, 100);
  endtask

`ifdef WINDOW_DISC_REFRACTORY_EN
  task automatic test_refractory();
    logic [1:0] exp_st [13] = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3,
                                2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    stop_max = 16'd3; refract_len = 16'd4; ch_en = 8'h03; thresh_in = 8'h03;
    for (int t = 0; t < 13; t++) begin
      do_tick();
      checks++;
      if (state !== exp_st[t]) begin
        failures++; $display("FAIL refract_seq tick%0d got=%0d exp=%0d", t + 1, state, exp_st[t]);
      end
    end
    thresh_in = 8'h00;
    for (int t = 0; t < 6; t++) do_tick();
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b0; sample_tick = 1'b0; fsm_en = 1'b0; combine_or = 1'b0;
    ch_en = '0; thresh_in = '0; edge_type = '0; start_win = '0; stop_win = '0;
    stop_max = '0; refract_len = '0; clear_evt = 1'b0;
    for (int i = 0; i < N_CH; i++) set_win(i, 0, 100);
    repeat (2) @(posedge dataclk);
    #1;
    reset_n = 1'b1;
    idle_cycle();
    test_reset();
    test_and_stim();
    test_and_fail();
    test_or_mode();
    test_fsm_en_clear();
    test_boundaries();
`ifdef WINDOW_DISC_REFRACTORY_EN
    test_refractory();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
